// File: rtl/async_wr_ctrl_prog_pkg.sv
// Shared FIFO pointer helpers: Gray/binary conversion and address-width derivation.
// Used by the write-side controller and by the read-side controller.
package async_wr_ctrl_prog_pkg;

  localparam int PTR_FN_W = 32;

  // Address width for a power-of-two depth; pointers carry one extra wrap bit.
  function automatic int ptr_aw(input int depth);
    return $clog2(depth);
  endfunction

  // Width-generic: callers zero-extend into 32 bits and cast the result back down.
  function automatic logic [PTR_FN_W-1:0] bin2gray(input logic [PTR_FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_FN_W-1:0] gray2bin(input logic [PTR_FN_W-1:0] g);
    logic [PTR_FN_W-1:0] b;
    b[PTR_FN_W-1] = g[PTR_FN_W-1];
    for (int i = PTR_FN_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/async_wr_ctrl_prog_ptr_sync.sv
// Multi-flop synchronizer for a Gray-coded FIFO pointer crossing into i_clk.
// Every flop clears asynchronously so both FIFO sides restart from pointer 0.
module ptr_sync #(
  parameter int W      = 4,
  parameter int STAGES = 2
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  (* ASYNC_REG = "TRUE" *) logic [W-1:0] r_sync [STAGES];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_sync[i] <= '0;
      end
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/async_wr_ctrl_prog.sv
// Write-side controller of the dual-clock FIFO: pointer, RAM address, full/almost-full,
// fill level and sticky overflow. Macro ASYNC_WR_CTRL_SYNC_EN adds an internal rd-pointer synchronizer.
module async_wr_ctrl_prog
  import async_wr_ctrl_prog_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int SYNC_STAGES = 2,
  localparam int AW         = ptr_aw(DEPTH),
  localparam int PW         = AW + 1
) (
  input  logic          i_wr_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic [PW-1:0] i_afull_thresh,
  input  logic          i_ovf_clr,
  input  logic [PW-1:0] i_rd_ptr_gray,
  output logic [AW-1:0] o_wr_addr,
  output logic [PW-1:0] o_wr_ptr,
  output logic          o_wr_full,
  output logic          o_wr_afull,
  output logic [PW-1:0] o_wr_count,
  output logic          o_wr_ovf
);

  if ((DEPTH < 4) || ((1 << AW) != DEPTH)) begin : g_depth_check
    $error("DEPTH must be a power of two and at least 4");
  end
  if (SYNC_STAGES < 2) begin : g_stages_check
    $error("SYNC_STAGES must be at least 2");
  end

  logic [PW-1:0] r_wr_ptr_bin;
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_wr_count;
  logic          r_wr_full;
  logic          r_wr_afull;
  logic          r_wr_ovf;

  logic [PW-1:0] w_rd_gray;
  logic [PW-1:0] w_rd_bin;
  logic          w_accept;
  logic [PW-1:0] w_bin_nxt;
  logic [PW-1:0] w_cnt_nxt;

`ifdef ASYNC_WR_CTRL_SYNC_EN
  ptr_sync #(
    .W      (PW),
    .STAGES (SYNC_STAGES)
  ) u_rd_sync (
    .i_clk (i_wr_clk),
    .i_rst (i_rst),
    .i_d   (i_rd_ptr_gray),
    .o_q   (w_rd_gray)
  );
`else
  assign w_rd_gray = i_rd_ptr_gray;
`endif

  // Handshake: i_wr_en is valid, ~o_wr_full is ready; a word is taken on each edge where
  // both are high, and i_wr_en while full is dropped (and flagged in o_wr_ovf).
  assign w_accept  = i_wr_en & ~r_wr_full;
  assign w_bin_nxt = r_wr_ptr_bin + PW'(w_accept);
  assign w_rd_bin  = PW'(gray2bin(PTR_FN_W'(w_rd_gray)));
  // Stale read pointer only makes the count too high, so flags err toward full.
  assign w_cnt_nxt = w_bin_nxt - w_rd_bin;

  always_ff @(posedge i_wr_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr_bin <= '0;
      r_wr_ptr     <= '0;
      r_wr_count   <= '0;
      r_wr_full    <= 1'b0;
      r_wr_afull   <= 1'b0;
      r_wr_ovf     <= 1'b0;
    end else begin
      r_wr_ptr_bin <= w_bin_nxt;
      r_wr_ptr     <= PW'(bin2gray(PTR_FN_W'(w_bin_nxt)));
      r_wr_count   <= w_cnt_nxt;
      r_wr_full    <= (w_cnt_nxt == PW'(DEPTH));
      r_wr_afull   <= (w_cnt_nxt >= i_afull_thresh);
      r_wr_ovf     <= (i_wr_en & r_wr_full) | (r_wr_ovf & ~i_ovf_clr);
    end
  end

  assign o_wr_addr  = r_wr_ptr_bin[AW-1:0];
  assign o_wr_ptr   = r_wr_ptr;
  assign o_wr_full  = r_wr_full;
  assign o_wr_afull = r_wr_afull;
  assign o_wr_count = r_wr_count;
  assign o_wr_ovf   = r_wr_ovf;

endmodule

// File: tb/tb_async_wr_ctrl_prog.sv
// Directed bench for async_wr_ctrl_prog at DEPTH=8 in the default build (no internal sync).
module tb_async_wr_ctrl_prog;

  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int PW    = 4;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [PW-1:0] afull_thresh;
  logic          ovf_clr;
  logic [PW-1:0] rd_ptr_gray;
  logic [AW-1:0] wr_addr;
  logic [PW-1:0] wr_ptr;
  logic          wr_full;
  logic          wr_afull;
  logic [PW-1:0] wr_count;
  logic          wr_ovf;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_q[$];

  async_wr_ctrl_prog #(.DEPTH(DEPTH), .SYNC_STAGES(2)) dut (
    .i_wr_clk       (clk),
    .i_rst          (rst),
    .i_wr_en        (wr_en),
    .i_afull_thresh (afull_thresh),
    .i_ovf_clr      (ovf_clr),
    .i_rd_ptr_gray  (rd_ptr_gray),
    .o_wr_addr      (wr_addr),
    .o_wr_ptr       (wr_ptr),
    .o_wr_full      (wr_full),
    .o_wr_afull     (wr_afull),
    .o_wr_count     (wr_count),
    .o_wr_ovf       (wr_ovf)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Driver tasks: inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [PW-1:0] thresh);
    wr_en        = 1'b0;
    ovf_clr      = 1'b0;
    rd_ptr_gray  = '0;
    afull_thresh = thresh;
    rst          = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [PW-1:0] to_gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check_addr_from_q(input string tag);
    logic [31:0] e;
    if (exp_q.size() == 0) begin
      check({tag, "_q_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(wr_addr), e);
    end
  endtask

  logic [31:0] gray_seq [8] = '{32'h1, 32'h3, 32'h2, 32'h6, 32'h7, 32'h5, 32'h4, 32'hC};

  initial begin
    rst = 1'b1; wr_en = 1'b0; ovf_clr = 1'b0; rd_ptr_gray = '0; afull_thresh = 4'd9;
    #2;
    check("rst_ptr",   32'(wr_ptr),   32'd0);
    check("rst_count", 32'(wr_count), 32'd0);
    check("rst_flags", {28'd0, wr_full, wr_afull, wr_ovf, 1'b0}, 32'd0);

    // 1: eight back-to-back writes, threshold above DEPTH so afull never rises
    do_reset(4'd9);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i));
    wr_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check_addr_from_q("t1_addr");
      tick();
      check("t1_ptr", 32'(wr_ptr), gray_seq[k]);
      check("t1_full", 32'(wr_full), (k == 7) ? 32'd1 : 32'd0);
    end
    check("t1_count", 32'(wr_count), 32'd8);
    check("t1_afull_never", 32'(wr_afull), 32'd0);
    check("t1_ovf_clean", 32'(wr_ovf), 32'd0);

    // 2: overflow while full, clear, then set-wins-over-clear
    tick();
    check("t2_ovf_set", 32'(wr_ovf), 32'd1);
    tick();
    check("t2_ptr_hold", 32'(wr_ptr), 32'hC);
    check("t2_addr_hold", 32'(wr_addr), 32'd0);
    check("t2_count_hold", 32'(wr_count), 32'd8);
    wr_en = 1'b0; ovf_clr = 1'b1;
    tick();
    check("t2_ovf_clr", 32'(wr_ovf), 32'd0);
    wr_en = 1'b1; ovf_clr = 1'b1;
    tick();
    check("t2_set_wins", 32'(wr_ovf), 32'd1);
    wr_en = 1'b0; ovf_clr = 1'b0;

    // 3: almost-full at 6, then threshold 0
    do_reset(4'd6);
    wr_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check("t3_count", 32'(wr_count), 32'(k));
      check("t3_afull", 32'(wr_afull), (k >= 6) ? 32'd1 : 32'd0);
    end
    do_reset(4'd0);
    check("t3_th0_pre", 32'(wr_afull), 32'd0);
    tick();
    check("t3_th0_post", 32'(wr_afull), 32'd1);

    // 4: 20 writes with read pointer trailing by three
    do_reset(4'd9);
    for (int j = 1; j <= 20; j++) exp_q.push_back(32'((j - 1) % 8));
    wr_en = 1'b1;
    for (int j = 1; j <= 20; j++) begin
      rd_ptr_gray = (j >= 3) ? to_gray(PW'(j - 3)) : '0;
      check_addr_from_q("t4_addr");
      tick();
      check("t4_no_full", 32'(wr_full), 32'd0);
    end
    check("t4_count", 32'(wr_count), 32'd3);
    check("t4_addr_wrapped", 32'(wr_addr), 32'd4);
    wr_en = 1'b0;

    // 5: asynchronous reset mid-burst
    do_reset(4'd9);
    wr_en = 1'b1;
    tick(); tick(); tick();
    check("t5_pre_count", 32'(wr_count), 32'd3);
    #2 rst = 1'b1;
    #1;
    check("t5_async_ptr",   32'(wr_ptr),   32'd0);
    check("t5_async_addr",  32'(wr_addr),  32'd0);
    check("t5_async_count", 32'(wr_count), 32'd0);
    tick();
    rst = 1'b0;
    check("t5_resume_addr0", 32'(wr_addr), 32'd0);
    tick();
    check("t5_resume_ptr", 32'(wr_ptr), 32'd1);
    check("t5_resume_addr1", 32'(wr_addr), 32'd1);

    // 6: read-pointer advance seen one edge later without the internal sync
    do_reset(4'd9);
    wr_en = 1'b1;
    repeat (5) tick();
    wr_en = 1'b0;
    check("t6_count5", 32'(wr_count), 32'd5);
    rd_ptr_gray = to_gray(4'd1);
    #2;
    check("t6_before_edge", 32'(wr_count), 32'd5);
    tick();
    check("t6_after_edge", 32'(wr_count), 32'd4);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
